alu_pipe: RTL
=============

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width in bits (legal 8..64, power of two).
REQ-002 SHALL provide localparam SHW = $clog2(WIDTH), rotate-amount width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block accepts request this cycle.
REQ-007 SHALL have port op  input  4  operation code (alu_pkg enum).
REQ-008 SHALL have ports a, b  input  WIDTH  operands.
REQ-009 SHALL have port out_valid  output  1  result register holds unconsumed result.
REQ-010 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-011 SHALL have ports result  output  WIDTH, zero  output 1, carry  output 1, leu  output 1  registered result and flags.

Function
REQ-012 SHALL accept a request on any cycle with in_valid && in_ready; op, a, b sampled on that edge only.
REQ-013 SHALL drive in_ready = (state == IDLE) && (!out_valid || out_ready), combinationally.
REQ-014 SHALL implement ops: ADD=0 a+b; SUB=1 a-b; NOR=2 ~(a|b); NOT=3 ~b; ROL=4 b rotated left by a[SHW-1:0]; ROR=5 b rotated right by a[SHW-1:0]; MUL=6 low WIDTH bits of a*b unsigned; codes 7..15 reserved.
REQ-015 SHALL produce result 0 for reserved codes, with no error signalled.
REQ-016 SHALL register single-cycle ops (0..5, reserved): out_valid=1 and result valid the cycle after accept (latency 1).
REQ-017 SHALL execute MUL iteratively via shift-add, one multiplier bit per cycle, in_ready=0 while BUSY; out_valid asserts exactly WIDTH+1 cycles after accept.
REQ-018 SHALL use FSM states IDLE, BUSY: IDLE->BUSY on accepted MUL; BUSY->IDLE when iteration counter reaches WIDTH-1, loading product into result register.
REQ-019 SHALL hold result, flags, out_valid stable while out_valid && !out_ready.
REQ-020 SHALL clear out_valid on out_valid && out_ready unless a new request is accepted the same cycle (back-to-back throughput 1/cycle for single-cycle ops).
REQ-021 SHALL set zero = (result == 0) for every op.
REQ-022 SHALL set carry = carry-out of a+b for ADD, = (a >= b unsigned) (no borrow) for SUB, 0 for all other ops.
REQ-023 SHALL set leu = (a <= b unsigned) for every op, sampled from accepted operands.
REQ-024 SHALL treat rotate amount 0 as identity and use only a[SHW-1:0], ignoring upper bits of a.

Reset
REQ-025 SHALL, on reset high at a rising edge, force state=IDLE, out_valid=0, result=0, zero=0, carry=0, leu=0, iteration counter=0.
REQ-026 SHALL abandon an in-progress MUL on reset without emitting a result.
REQ-027 SHALL drive in_ready=0 during the reset cycle and accept no request on it.

Structure
REQ-028 SHALL place op enum (alu_op_t, 4 bits, codes per REQ-014) and state enum in shared package alu_pkg.
REQ-029 SHALL implement rotate as sub-module rotator (parameters WIDTH, DIR), log2 stages, instantiated twice (left, right).
REQ-030 SHALL contain no latches and no multiple drivers; combinational next-state in one always_comb.

Verification
REQ-031 WIDTH=32: ADD a=32'hFFFF_FFFF b=1, out_ready=1 -> next cycle result=0, zero=1, carry=1, leu=0.
REQ-032 WIDTH=32: ROR a=33 (amount 1) b=32'h0000_0001 -> result=32'h8000_0000; ROL a=31 b=32'h0000_0003 -> result=32'h8000_0001.
REQ-033 WIDTH=32: MUL a=32'h0001_0001 b=32'h0000_FFFF -> in_ready=0 for 32 cycles, out_valid at cycle 33, result=32'hFFFF_FFFF.
REQ-034 Backpressure: SUB a=5 b=7 with out_ready=0 for 4 cycles -> result=32'hFFFF_FFFE, carry=0, leu=1 held stable, in_ready=0, then drained on out_ready=1.
REQ-035 Reset mid-MUL at cycle 10 -> out_valid=0, in_ready=1 cycle after reset drops, no result emitted.
REQ-036 WIDTH=8: back-to-back NOR, NOT, op=9 with out_ready=1 -> results 8'h.. per REQ-014, op=9 gives 0, zero=1, one result per cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode and FSM state types for the pipelined ALU
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_NOR = 4'd2,
        OP_NOT = 4'd3,
        OP_ROL = 4'd4,
        OP_ROR = 4'd5,
        OP_MUL = 4'd6
    } alu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } alu_state_t;

endpackage

// File: rtl/rotator.sv
// rtl/rotator.sv - log2-stage barrel rotator, DIR=0 rotates left, DIR=1 rotates right
module rotator #(
    parameter int WIDTH = 32,
    parameter bit DIR   = 1'b0
) (
    input  logic [WIDTH-1:0]         data_i,
    input  logic [$clog2(WIDTH)-1:0] amt_i,
    output logic [WIDTH-1:0]         data_o
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] v;

    // Stage s rotates by 2**s when amount bit s is set.
    always_comb begin
        v = data_i;
        for (int s = 0; s < SHW; s++) begin
            if (amt_i[s]) begin
                if (DIR) begin
                    v = (v >> (1 << s)) | (v << (WIDTH - (1 << s)));
                end else begin
                    v = (v << (1 << s)) | (v >> (WIDTH - (1 << s)));
                end
            end
        end
        data_o = v;
    end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - single-entry ALU with registered result and iterative shift-add multiply
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             leu
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_t       state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             mul_leu_q, mul_leu_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             leu_q, leu_d;

    logic             accept;
    logic [WIDTH-1:0] rol_res, ror_res, alu_res, acc_next;
    logic [WIDTH:0]   add_full;
    logic             alu_carry;

    assign in_ready = !reset && (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    rotator #(.WIDTH(WIDTH), .DIR(1'b0)) u_rol (
        .data_i (b),
        .amt_i  (a[SHW-1:0]),
        .data_o (rol_res)
    );

    rotator #(.WIDTH(WIDTH), .DIR(1'b1)) u_ror (
        .data_i (b),
        .amt_i  (a[SHW-1:0]),
        .data_o (ror_res)
    );

    // Single-cycle datapath; MUL and reserved codes fall through to zero here.
    always_comb begin
        add_full  = {1'b0, a} + {1'b0, b};
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res   = add_full[WIDTH-1:0];
                alu_carry = add_full[WIDTH];
            end
            OP_SUB: begin
                alu_res   = a - b;
                alu_carry = (a >= b);
            end
            OP_NOR:  alu_res = ~(a | b);
            OP_NOT:  alu_res = ~b;
            OP_ROL:  alu_res = rol_res;
            OP_ROR:  alu_res = ror_res;
            default: alu_res = '0;
        endcase
    end

    assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        mul_leu_d   = mul_leu_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        leu_d       = leu_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        state_d   = BUSY;
                        cnt_d     = '0;
                        mcand_d   = a;
                        mplier_d  = b;
                        acc_d     = '0;
                        mul_leu_d = (a <= b);
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_res;
                        zero_d      = (alu_res == '0);
                        carry_d     = alu_carry;
                        leu_d       = (a <= b);
                    end
                end
            end
            BUSY: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // Last multiplier bit: publish the product straight from the adder.
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    result_d    = acc_next;
                    zero_d      = (acc_next == '0);
                    carry_d     = 1'b0;
                    leu_d       = mul_leu_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            mul_leu_q   <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            leu_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            mul_leu_q   <= mul_leu_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            leu_q       <= leu_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign leu       = leu_q;

endmodule
